vc_arbiter: RTL and testbench
=============================

# vc_arbiter

Weighted round-robin scheduler between the VC0 and VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs of the PCIe transmission-layer datapath. Each cycle it pops at most one head word from an eligible VC FIFO, routes it by its destination bit, and pushes it one cycle later into D0 or D1. VC0 is favoured by a configurable weight. VC1 is never starved while it is eligible. Backpressure from the destination FIFOs blocks only the channel whose head word targets a full destination.

## Interface
Parameters:
- DATA_W, 6, word width of VC and D FIFO data.
- DEST_BIT, 4, bit index of the head word selecting the destination: 0 selects D0, 1 selects D1.
- WEIGHT_VC0, 4, maximum consecutive VC0 grants while VC1 is eligible. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- arb_en  in  1  scheduler enable. When low, no pops are issued.
- data_out_VC0  in  DATA_W  head word of VC0 FIFO (first-word-fall-through, valid while not empty).
- data_out_VC1  in  DATA_W  head word of VC1 FIFO.
- empty_fifo_VC0  in  1  VC0 FIFO empty.
- empty_fifo_VC1  in  1  VC1 FIFO empty.
- almost_full_D0  in  1  D0 FIFO cannot accept the next push plus one in flight.
- almost_full_D1  in  1  D1 FIFO, same meaning.
- pop_VC0_fifo  out  1  combinational pop to VC0 FIFO.
- pop_VC1_fifo  out  1  combinational pop to VC1 FIFO.
- push_D0  out  1  registered push to D0 FIFO.
- push_D1  out  1  registered push to D1 FIFO.
- data_in_D0  out  DATA_W  registered word for D0.
- data_in_D1  out  DATA_W  registered word for D1.
- idle  out  1  registered: both VC FIFOs empty and no push in flight.

## Operation
- FSM states:
  - DISABLED (reset state): no pops. Moves to ACTIVE on the first cycle arb_en=1.
  - ACTIVE: arbitration runs. Returns to DISABLED when arb_en=0. A push already registered still completes.
- Eligibility:
  - elig0 = !empty_fifo_VC0 && !almost_full_D(data_out_VC0[DEST_BIT]).
  - elig1 = the same for VC1.
- Credit counter cnt0:
  - Width 4 bits.
  - Counts VC0 grants since the last VC1 grant and saturates at WEIGHT_VC0.
- Grant rule in ACTIVE, evaluated combinationally:
  - Grant VC1 if elig1 && (cnt0==WEIGHT_VC0 || !elig0).
  - Otherwise grant VC0 if elig0.
  - Otherwise grant nothing.
- Counter update:
  - A VC1 grant clears cnt0 to 0.
  - A VC0 grant increments cnt0, saturating.
  - No grant leaves cnt0 unchanged.
- A grant asserts the matching pop_VCx_fifo in the same cycle. The two pops are never high together.
- Routing on the next edge:
  - The granted head word is captured into data_in_Dx, where x is the word's DEST_BIT.
  - push_Dx goes high for exactly one cycle. The other push stays 0.
  - Non-selected data_in holds its previous value.
- almost_full_Dx must assert with at least one free slot remaining. The arbiter relies on this margin to absorb the one push in flight.
- idle = empty_fifo_VC0 && empty_fifo_VC1 && !push_D0 && !push_D1, registered.

## Timing
- Reset values: state DISABLED, cnt0=0, push_D0=push_D1=0, data_in_D0=data_in_D1=0, idle=1. Pops are 0 during reset.
- Latency is one cycle: a pop in cycle N produces the push in cycle N+1. Sustained throughput is one word per cycle.
- Back-to-back pops on the same FIFO are allowed. The FIFO presents its new head in cycle N+1.
- Simultaneous events:
  - If both VCs are eligible and cnt0<WEIGHT_VC0, VC0 wins.
  - At cnt0==WEIGHT_VC0, VC1 wins once, then cnt0 returns to 0.
- Head-of-line blocking:
  - If a VC0 head targets a full D0, VC0 is ineligible, and VC1 may proceed to D1 in the same cycle.
  - cnt0 is not reset by VC0 being blocked.
- arb_en falling in cycle N means no pop in cycle N.
- Reset asserted mid-transfer discards any push in flight: push outputs are 0 on the next edge.

## Test plan
- Reset, then release with both FIFOs empty and arb_en=1 -> no pops, push_D0=push_D1=0, idle=1, cnt0=0.
- VC0 holds 3 words 0x05, 0x15, 0x0A; VC1 empty -> pops in 3 consecutive cycles. One cycle later: D0 gets 0x05, D1 gets 0x15, D0 gets 0x0A (bit 4). idle=1 after the last push.
- Both FIFOs hold 12 words all bound for D0, WEIGHT_VC0=4 -> grant sequence VC0×4, VC1, VC0×4, VC1, …; never both pops high.
- VC0 head 0x10 (to D1) with almost_full_D1=1, VC1 head 0x02 (to D0) -> VC1 is popped every cycle and VC0 is held. After almost_full_D1 drops, VC0 0x10 reaches data_in_D1 one cycle after its pop.
- arb_en=0 for 5 cycles with both FIFOs non-empty -> no pops. A push registered before arb_en fell still appears once. Arbitration resumes on the cycle after arb_en=1.
- Assert reset in the cycle after a VC1 pop -> push_D0=push_D1=0 on the next edge, word dropped, cnt0=0, state DISABLED.

Source files
------------

// File: rtl/vc_arbiter_if.sv
// VC-to-destination FIFO handshake bundle for the vc_arbiter scheduler.
// The master modport is the arbiter's view; slave is the FIFO/environment side.
interface vc_arbiter_if #(
    parameter int DATA_W = 6
);
    logic              arb_en;
    logic [DATA_W-1:0] data_out_VC0;
    logic [DATA_W-1:0] data_out_VC1;
    logic              empty_fifo_VC0;
    logic              empty_fifo_VC1;
    logic              almost_full_D0;
    logic              almost_full_D1;
    logic              pop_VC0_fifo;
    logic              pop_VC1_fifo;
    logic              push_D0;
    logic              push_D1;
    logic [DATA_W-1:0] data_in_D0;
    logic [DATA_W-1:0] data_in_D1;
    logic              idle;

    modport master (
        input  arb_en, data_out_VC0, data_out_VC1, empty_fifo_VC0, empty_fifo_VC1,
               almost_full_D0, almost_full_D1,
        output pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_in_D0, data_in_D1, idle
    );

    modport slave (
        output arb_en, data_out_VC0, data_out_VC1, empty_fifo_VC0, empty_fifo_VC1,
               almost_full_D0, almost_full_D1,
        input  pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_in_D0, data_in_D1, idle
    );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler moving head words from the VC0/VC1 FIFOs
// into the D0/D1 destination FIFOs. VC0 gets up to WEIGHT_VC0 consecutive
// grants while VC1 waits; VC1 then wins once. Pops are combinational, the
// routed push and its word are registered one cycle later.
module vc_arbiter #(
    parameter int DATA_W     = 6,
    parameter int DEST_BIT   = 4,
    parameter int WEIGHT_VC0 = 4
) (
    input  logic         clk,
    input  logic         reset,
    vc_arbiter_if.master bus
);
    typedef enum logic {
        DISABLED = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [3:0] WEIGHT = 4'(WEIGHT_VC0);

    state_t            state;
    logic [3:0]        cnt0;
    logic              dest0;
    logic              dest1;
    logic              elig0;
    logic              elig1;
    logic              run;
    logic              grant0;
    logic              grant1;
    logic              granted;
    logic              grant_dest;
    logic [DATA_W-1:0] grant_word;

    // A channel is eligible when it has a head word and that word's destination has room.
    assign dest0 = bus.data_out_VC0[DEST_BIT];
    assign dest1 = bus.data_out_VC1[DEST_BIT];
    assign elig0 = !bus.empty_fifo_VC0 && !(dest0 ? bus.almost_full_D1 : bus.almost_full_D0);
    assign elig1 = !bus.empty_fifo_VC1 && !(dest1 ? bus.almost_full_D1 : bus.almost_full_D0);

    // NOTE: pops are gated by reset and arb_en directly, so they drop in the
    // same cycle either input changes rather than waiting for the FSM edge.
    assign run    = (state == ACTIVE) && bus.arb_en && !reset;
    assign grant1 = run && elig1 && ((cnt0 == WEIGHT) || !elig0);
    assign grant0 = run && elig0 && !grant1;

    assign granted    = grant0 || grant1;
    assign grant_dest = grant1 ? dest1 : dest0;
    assign grant_word = grant1 ? bus.data_out_VC1 : bus.data_out_VC0;

    assign bus.pop_VC0_fifo = grant0;
    assign bus.pop_VC1_fifo = grant1;

    // FSM, credit counter, registered routing of the granted word, and idle flag.
    // NOTE: every register here uses non-blocking assignment so all of them
    // see the pre-edge values of each other (idle reads the old push flags).
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= DISABLED;
            cnt0           <= 4'd0;
            bus.push_D0    <= 1'b0;
            bus.push_D1    <= 1'b0;
            bus.data_in_D0 <= '0;
            bus.data_in_D1 <= '0;
            bus.idle       <= 1'b1;
        end else begin
            case (state)
                DISABLED: if (bus.arb_en)  state <= ACTIVE;
                ACTIVE:   if (!bus.arb_en) state <= DISABLED;
                default:                   state <= DISABLED;
            endcase

            if (grant1) begin
                cnt0 <= 4'd0;
            end else if (grant0 && (cnt0 != WEIGHT)) begin
                cnt0 <= cnt0 + 4'd1;
            end

            bus.push_D0 <= granted && !grant_dest;
            bus.push_D1 <= granted && grant_dest;
            if (granted && !grant_dest) bus.data_in_D0 <= grant_word;
            if (granted && grant_dest)  bus.data_in_D1 <= grant_word;

            bus.idle <= bus.empty_fifo_VC0 && bus.empty_fifo_VC1 && !bus.push_D0 && !bus.push_D1;
        end
    end
endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: small FIFO models feed the VC heads, and
// per-cycle logs of pops and pushes are compared with hand-derived sequences.
module tb_vc_arbiter;
    localparam int DATA_W = 6;

    logic clk = 1'b0;
    logic reset;

    vc_arbiter_if #(.DATA_W(DATA_W)) bus ();

    vc_arbiter #(
        .DATA_W    (DATA_W),
        .DEST_BIT  (4),
        .WEIGHT_VC0(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] d0_log[$];
    logic [DATA_W-1:0] d1_log[$];
    logic [1:0]        pop_log[$];
    logic [1:0]        exp_pop[$];
    logic [DATA_W-1:0] exp_d0[$];
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO model heads to the arbiter.
    task automatic refresh();
        bus.empty_fifo_VC0 = (q0.size() == 0);
        bus.empty_fifo_VC1 = (q1.size() == 0);
        bus.data_out_VC0   = (q0.size() != 0) ? q0[0] : '0;
        bus.data_out_VC1   = (q1.size() != 0) ? q1[0] : '0;
    endtask

    // One clock: sample pops/pushes mid-cycle, cross the edge, retire popped heads.
    task automatic cycle();
        logic p0, p1;
        #3;
        p0 = bus.pop_VC0_fifo;
        p1 = bus.pop_VC1_fifo;
        pop_log.push_back({p1, p0});
        if (bus.push_D0) d0_log.push_back(bus.data_in_D0);
        if (bus.push_D1) d1_log.push_back(bus.data_in_D1);
        @(posedge clk);
        #1;
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        d0_log.delete();
        d1_log.delete();
    endtask

    // Reset pulse followed by one enabled cycle so the FSM sits in ACTIVE.
    task automatic restart();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        clear_logs();
    endtask

    initial begin
        int i0;
        int i1;
        reset              = 1'b1;
        bus.arb_en         = 1'b0;
        bus.almost_full_D0 = 1'b0;
        bus.almost_full_D1 = 1'b0;
        refresh();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Reset state and release with empty FIFOs.
        check("rst_idle", bus.idle, 1'b1);
        check("rst_push", {bus.push_D1, bus.push_D0}, 2'b00);
        reset      = 1'b0;
        bus.arb_en = 1'b1;
        repeat (3) cycle();
        #1;
        check("empty_pops", {bus.pop_VC1_fifo, bus.pop_VC0_fifo}, 2'b00);
        check("empty_push", {bus.push_D1, bus.push_D0}, 2'b00);
        check("empty_idle", bus.idle, 1'b1);
        check("empty_cnt0", dut.cnt0, 4'd0);
        check("empty_data", {bus.data_in_D1, bus.data_in_D0}, 12'h000);

        // VC0 alone: three words routed by bit 4.
        clear_logs();
        q0 = {6'h05, 6'h15, 6'h0A};
        refresh();
        repeat (3) cycle();
        check("vc0_idle_busy", bus.idle, 1'b0);
        repeat (4) cycle();
        check("vc0_pop_a", pop_log[0], 2'b01);
        check("vc0_pop_b", pop_log[1], 2'b01);
        check("vc0_pop_c", pop_log[2], 2'b01);
        check("vc0_pop_end", pop_log[3], 2'b00);
        check("vc0_d0_n", 8'(d0_log.size()), 8'd2);
        check("vc0_d1_n", 8'(d1_log.size()), 8'd1);
        if (d0_log.size() == 2) begin
            check("vc0_d0_a", d0_log[0], 6'h05);
            check("vc0_d0_b", d0_log[1], 6'h0A);
        end
        if (d1_log.size() == 1) check("vc0_d1_a", d1_log[0], 6'h15);
        check("vc0_idle_done", bus.idle, 1'b1);
        check("vc0_cnt0", dut.cnt0, 4'd3);

        // Credit saturation, then VC1 wins immediately at cnt0 == weight.
        q0 = {6'h01, 6'h02, 6'h03};
        refresh();
        repeat (3) cycle();
        check("sat_cnt0", dut.cnt0, 4'd4);
        clear_logs();
        q0 = {6'h08, 6'h09};
        q1 = {6'h0C};
        refresh();
        repeat (2) cycle();
        check("sat_first", pop_log[0], 2'b10);
        check("sat_second", pop_log[1], 2'b01);
        check("sat_cnt0_after", dut.cnt0, 4'd1);
        repeat (3) cycle();

        // Weighted round-robin with both VCs full of D0-bound words.
        restart();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(6'(8'h01 + i));
            q1.push_back(6'(8'h20 + i));
        end
        refresh();
        repeat (26) cycle();
        exp_pop.delete();
        exp_d0.delete();
        i0 = 0;
        i1 = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 15) exp_pop.push_back((i % 5 == 4) ? 2'b10 : 2'b01);
            else if (i < 24) exp_pop.push_back(2'b10);
            else exp_pop.push_back(2'b00);
        end
        for (int i = 0; i < 24; i++) begin
            if (exp_pop[i] == 2'b01) begin
                exp_d0.push_back(6'(8'h01 + i0));
                i0++;
            end else begin
                exp_d0.push_back(6'(8'h20 + i1));
                i1++;
            end
        end
        for (int i = 0; i < 26; i++) check($sformatf("wrr_pop%0d", i), pop_log[i], exp_pop[i]);
        check("wrr_d0_n", 8'(d0_log.size()), 8'd24);
        check("wrr_d1_n", 8'(d1_log.size()), 8'd0);
        if (d0_log.size() == 24)
            for (int i = 0; i < 24; i++) check($sformatf("wrr_d0_%0d", i), d0_log[i], exp_d0[i]);

        // Head-of-line blocking: VC0 head bound for a full D1, VC1 proceeds to D0.
        restart();
        q0 = {6'h10};
        q1 = {6'h02, 6'h03, 6'h06};
        bus.almost_full_D1 = 1'b1;
        refresh();
        repeat (3) cycle();
        check("hol_pop_a", pop_log[0], 2'b10);
        check("hol_pop_b", pop_log[1], 2'b10);
        check("hol_pop_c", pop_log[2], 2'b10);
        bus.almost_full_D1 = 1'b0;
        cycle();
        check("hol_release_pop", pop_log[3], 2'b01);
        check("hol_push", {bus.push_D1, bus.push_D0}, 2'b10);
        check("hol_data_d1", bus.data_in_D1, 6'h10);
        check("hol_d0_n", 8'(d0_log.size()), 8'd3);
        if (d0_log.size() == 3) check("hol_d0_c", d0_log[2], 6'h06);
        cycle();

        // arb_en low for five cycles with both VCs non-empty.
        restart();
        q0 = {6'h01, 6'h02, 6'h03};
        q1 = {6'h04};
        refresh();
        cycle();
        bus.arb_en = 1'b0;
        #1;
        check("en_off_pops", {bus.pop_VC1_fifo, bus.pop_VC0_fifo}, 2'b00);
        check("en_inflight", {bus.push_D1, bus.push_D0}, 2'b01);
        check("en_inflight_data", bus.data_in_D0, 6'h01);
        clear_logs();
        repeat (5) cycle();
        for (int i = 0; i < 5; i++) check($sformatf("en_off_pop%0d", i), pop_log[i], 2'b00);
        check("en_off_pushes", 8'(d0_log.size() + d1_log.size()), 8'd1);
        check("en_off_state", dut.state, 1'b0);
        bus.arb_en = 1'b1;
        clear_logs();
        repeat (2) cycle();
        check("en_resume_wait", pop_log[0], 2'b00);
        check("en_resume_pop", pop_log[1], 2'b01);

        // Reset asserted in the cycle after a VC1 pop.
        restart();
        q0.delete();
        q1 = {6'h07};
        refresh();
        cycle();
        check("rstmid_pop", pop_log[0], 2'b10);
        check("rstmid_inflight", bus.data_in_D0, 6'h07);
        reset = 1'b1;
        q0 = {6'h01};
        refresh();
        cycle();
        check("rstmid_nopop", pop_log[1], 2'b00);
        check("rstmid_push", {bus.push_D1, bus.push_D0}, 2'b00);
        check("rstmid_data", bus.data_in_D0, 6'h00);
        check("rstmid_cnt0", dut.cnt0, 4'd0);
        check("rstmid_state", dut.state, 1'b0);
        reset = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
